expu_sum_acc: RTL and testbench



---
 rtl/expu_pkg.sv | 110 +++++++++++
 rtl/expu_fixed_to_fp.sv | 25 ++
 rtl/expu_sum_acc.sv | 111 +++++++++++
 tb/tb_expu_sum_acc.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/expu_pkg.sv
// Shared types and float/fixed conversion helpers for the exponential unit.
// The helpers work on 64-bit words so that any supported format and accumulator width can use them.
package expu_pkg;

    typedef enum logic [1:0] {FP32, FP16, FP8, FP16ALT} fp_format_e;

    localparam int ACC_INT_BITS_DFLT  = 12;
    localparam int ACC_FRAC_BITS_DFLT = 16;
    localparam int ACC_W              = ACC_INT_BITS_DFLT + ACC_FRAC_BITS_DFLT;
    localparam int MAX_W              = 64;

    typedef logic [MAX_W-1:0] word_t;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        NORM = 2'd1,
        OUT  = 2'd2
    } expu_acc_state_e;

    typedef struct packed {
        word_t value;
        logic  ovf;
    } fixed_res_t;

    function automatic int fp_exp_bits(input fp_format_e f);
        case (f)
            FP32:    return 8;
            FP16:    return 5;
            FP8:     return 5;
            default: return 8;
        endcase
    endfunction

    function automatic int fp_man_bits(input fp_format_e f);
        case (f)
            FP32:    return 23;
            FP16:    return 10;
            FP8:     return 2;
            default: return 7;
        endcase
    endfunction

    function automatic int fp_width(input fp_format_e f);
        return 1 + fp_exp_bits(f) + fp_man_bits(f);
    endfunction

    function automatic word_t ones(input int n);
        if (n >= MAX_W) return '1;
        return (word_t'(1) << n) - word_t'(1);
    endfunction

    // Exact float -> unsigned fixed point; sign ignored, denormals flushed, Inf/NaN and
    // anything too wide for the accumulator come back as all-ones with ovf set.
    function automatic fixed_res_t fp_to_fixed(input word_t val, input int exp_bits,
                                               input int man_bits, input int frac_bits,
                                               input int acc_w);
        fixed_res_t r;
        word_t      e_w;
        word_t      sig;
        int         e;
        int         bias;
        int         s;
        r.value = '0;
        r.ovf   = 1'b0;
        e_w  = (val >> man_bits) & ones(exp_bits);
        e    = int'(e_w);
        sig  = (val & ones(man_bits)) | (word_t'(1) << man_bits);
        bias = (1 << (exp_bits - 1)) - 1;
        s    = e - bias + frac_bits - man_bits;
        if (e == 0) begin
            r.value = '0;
        end else if (e_w == ones(exp_bits) || (man_bits + s) >= acc_w) begin
            r.value = ones(acc_w);
            r.ovf   = 1'b1;
        end else if (s >= 0) begin
            r.value = sig << s;
        end else if (-s < MAX_W) begin
            r.value = sig >> (-s);
        end
        return r;
    endfunction

    function automatic int lead_one(input word_t v, input int acc_w);
        int p;
        p = 0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < acc_w && v[i]) p = i;
        end
        return p;
    endfunction

    // Unsigned fixed point -> float, truncating; exponent overflow clamps to max finite.
    function automatic word_t fixed_to_fp(input word_t acc, input int acc_w, input int exp_bits,
                                          input int man_bits, input int frac_bits);
        int    p;
        int    e;
        int    e_max;
        word_t mant;
        if ((acc & ones(acc_w)) == '0) return '0;
        p     = lead_one(acc, acc_w);
        e     = p - frac_bits + (1 << (exp_bits - 1)) - 1;
        e_max = (1 << exp_bits) - 1;
        if (p >= man_bits) mant = (acc >> (p - man_bits)) & ones(man_bits);
        else               mant = (acc << (man_bits - p)) & ones(man_bits);
        if (e >= e_max) return (word_t'(e_max - 1) << man_bits) | ones(man_bits);
        if (e <= 0)     return '0;
        return (word_t'(e) << man_bits) | mant;
    endfunction

endpackage

// File: rtl/expu_fixed_to_fp.sv
// Combinational leading-one detect and pack of the accumulator back into the row float format.
module expu_fixed_to_fp
    import expu_pkg::*;
#(
    parameter fp_format_e FPFORMAT      = FP16ALT,
    parameter int         ACC_WIDTH     = ACC_W,
    parameter int         ACC_FRAC_BITS = ACC_FRAC_BITS_DFLT,
    localparam int        WIDTH         = fp_width(FPFORMAT)
) (
    input  logic [ACC_WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0]     fp_o
);

    word_t packed_fp;
    logic  unused_hi;

    always_comb begin
        packed_fp = fixed_to_fp(word_t'(acc_i), ACC_WIDTH, fp_exp_bits(FPFORMAT),
                                fp_man_bits(FPFORMAT), ACC_FRAC_BITS);
    end

    assign fp_o      = packed_fp[WIDTH-1:0];
    assign unused_hi = |(packed_fp >> WIDTH);

endmodule

// File: rtl/expu_sum_acc.sv
// Softmax denominator: saturating fixed-point sum of exp() beats per vector, renormalised to float.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; clear_i drops it.
module expu_sum_acc
    import expu_pkg::*;
#(
    parameter fp_format_e FPFORMAT      = FP16ALT,
    parameter int         ACC_INT_BITS  = ACC_INT_BITS_DFLT,
    parameter int         ACC_FRAC_BITS = ACC_FRAC_BITS_DFLT,
    parameter int         CNT_BITS      = 16,
    localparam int        WIDTH         = fp_width(FPFORMAT)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [WIDTH-1:0]    in_data_i,
    input  logic                in_last_i,
    output logic                sum_valid_o,
    input  logic                sum_ready_i,
    output logic [WIDTH-1:0]    sum_o,
    output logic [CNT_BITS-1:0] count_o,
    output logic                overflow_o
);

    localparam int ACC_WIDTH = ACC_INT_BITS + ACC_FRAC_BITS;
    localparam int EXP_BITS  = fp_exp_bits(FPFORMAT);
    localparam int MAN_BITS  = fp_man_bits(FPFORMAT);

    expu_acc_state_e       state_q;
    logic [ACC_WIDTH-1:0]  acc_q;
    logic [CNT_BITS-1:0]   cnt_q;
    logic                  ovf_q;
    logic [WIDTH-1:0]      sum_q;
    logic [CNT_BITS-1:0]   count_q;
    logic                  ovf_out_q;

    fixed_res_t            conv;
    logic [ACC_WIDTH-1:0]  operand;
    logic [ACC_WIDTH:0]    sum_wide;
    logic [ACC_WIDTH-1:0]  acc_d;
    logic [CNT_BITS-1:0]   cnt_d;
    logic                  conv_hi;
    logic                  beat_ovf;
    logic [WIDTH-1:0]      norm_fp;

    always_comb begin
        conv     = fp_to_fixed(word_t'(in_data_i), EXP_BITS, MAN_BITS, ACC_FRAC_BITS, ACC_WIDTH);
        operand  = conv.value[ACC_WIDTH-1:0];
        conv_hi  = |(conv.value >> ACC_WIDTH);
        sum_wide = {1'b0, acc_q} + {1'b0, operand};
        acc_d    = sum_wide[ACC_WIDTH] ? '1 : sum_wide[ACC_WIDTH-1:0];
        beat_ovf = conv.ovf | conv_hi | sum_wide[ACC_WIDTH];
        cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_BITS'(1);
    end

    expu_fixed_to_fp #(
        .FPFORMAT      (FPFORMAT),
        .ACC_WIDTH     (ACC_WIDTH),
        .ACC_FRAC_BITS (ACC_FRAC_BITS)
    ) u_norm (
        .acc_i (acc_q),
        .fp_o  (norm_fp)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q   <= ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            count_q   <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (in_valid_i) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_q | beat_ovf;
                        if (in_last_i) state_q <= NORM;
                    end
                end
                NORM: begin
                    sum_q     <= norm_fp;
                    count_q   <= cnt_q;
                    ovf_out_q <= ovf_q;
                    state_q   <= OUT;
                end
                OUT: begin
                    // Result registers are held; only the running sum is wiped for the next vector.
                    if (sum_ready_i) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= ACC;
                    end
                end
                default: state_q <= ACC;
            endcase
        end
    end

    assign in_ready_o  = (state_q == ACC);
    assign sum_valid_o = (state_q == OUT);
    assign sum_o       = sum_q;
    assign count_o     = count_q;
    assign overflow_o  = ovf_out_q;

endmodule

// File: tb/tb_expu_sum_acc.sv
// Bench for expu_sum_acc: directed plan cases plus random vectors against a real-arithmetic model.
module tb_expu_sum_acc;
    import expu_pkg::*;

    localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        sum_valid;
    logic        sum_ready;
    logic [15:0] sum;
    logic [15:0] count;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Expected results packed as {overflow, count, sum}.
    logic [32:0] exp_q[$];
    logic [15:0] vec_q[$];

    always #5 clk = ~clk;

    expu_sum_acc dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .sum_valid_o (sum_valid),
        .sum_ready_i (sum_ready),
        .sum_o       (sum),
        .count_o     (count),
        .overflow_o  (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // bfloat16 value times 2^16, floored; Inf/NaN or too large -> saturated with overflow.
    function automatic longint to_fixed(input logic [15:0] d, output bit o);
        int  e;
        int  m;
        real v;
        e = int'(d[14:7]);
        m = int'(d[6:0]);
        o = 1'b0;
        if (e == 0) return 0;
        if (e == 255) begin
            o = 1'b1;
            return ACC_MAX;
        end
        v = (128.0 + real'(m)) * (2.0 ** (e - 134)) * 65536.0;
        if (v >= 2.0 ** ACC_W) begin
            o = 1'b1;
            return ACC_MAX;
        end
        return longint'($floor(v));
    endfunction

    function automatic logic [15:0] to_bf16(input longint acc);
        int  p;
        int  ex;
        int  mant;
        real frac;
        if (acc == 0) return 16'h0000;
        p = 0;
        while ((acc >> (p + 1)) != 0) p++;
        frac = real'(acc) / (2.0 ** p) - 1.0;
        mant = int'($floor(frac * 128.0));
        ex   = p - 16 + 127;
        return {1'b0, ex[7:0], mant[6:0]};
    endfunction

    task automatic model_vector();
        longint acc = 0;
        longint f;
        bit     o = 1'b0;
        bit     bo;
        int     cnt = 0;
        foreach (vec_q[i]) begin
            f   = to_fixed(vec_q[i], bo);
            o   = o | bo;
            acc = acc + f;
            if (acc > ACC_MAX) begin
                acc = ACC_MAX;
                o   = 1'b1;
            end
            if (cnt < 65535) cnt++;
        end
        exp_q.push_back({o, 16'(cnt), to_bf16(acc)});
        vec_q.delete();
    endtask

    task automatic send_beat(input logic [15:0] d, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        check("in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'($urandom);
    endtask

    // Called right after the last beat's accepting edge.
    task automatic collect(input int wait_c);
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        @(negedge clk);
        check("lat_norm_valid", sum_valid, 0);
        check("norm_in_ready", in_ready, 0);
        @(negedge clk);
        check("lat_out_valid", sum_valid, 1);
        check("sum", sum, e[15:0]);
        check("count", count, e[31:16]);
        check("overflow", ovf, e[32]);
        for (int k = 0; k < wait_c; k++) begin
            @(negedge clk);
            check("hold_valid", sum_valid, 1);
            check("hold_sum", sum, e[15:0]);
            check("hold_count", count, e[31:16]);
            check("hold_in_ready", in_ready, 0);
        end
        sum_ready = 1'b1;
        @(posedge clk);
        #1;
        sum_ready = 1'b0;
        @(negedge clk);
        check("drain_valid", sum_valid, 0);
        check("drain_in_ready", in_ready, 1);
    endtask

    function automatic logic [15:0] rand_beat();
        int unsigned sel;
        logic [7:0]  e;
        sel = $urandom_range(0, 19);
        if (sel == 0)      e = 8'd0;
        else if (sel == 1) e = 8'hFF;
        else if (sel == 2) e = 8'($urandom_range(139, 200));
        else               e = 8'($urandom_range(100, 136));
        return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
    endfunction

    task automatic run_random_vector();
        int          len;
        logic [15:0] d;
        len = $urandom_range(1, 8);
        for (int i = 0; i < len; i++) begin
            d = rand_beat();
            vec_q.push_back(d);
            repeat ($urandom_range(0, 1)) @(posedge clk);
            send_beat(d, i == len - 1);
        end
        model_vector();
        collect($urandom_range(0, 3));
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        sum_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sum_valid", sum_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_count", count, 0);
        check("rst_overflow", ovf, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        // Single 1.0
        send_beat(16'h3F80, 1'b1);
        exp_q.push_back({1'b0, 16'd1, 16'h3F80});
        collect(0);

        // Four halves -> 2.0
        for (int i = 0; i < 4; i++) send_beat(16'h3F00, i == 3);
        exp_q.push_back({1'b0, 16'd4, 16'h4000});
        collect(1);

        // 2^-20 truncates to zero
        send_beat(16'h3580, 1'b0);
        send_beat(16'h3F80, 1'b1);
        exp_q.push_back({1'b0, 16'd2, 16'h3F80});
        collect(0);

        // All-zero vector
        send_beat(16'h0000, 1'b1);
        exp_q.push_back({1'b0, 16'd1, 16'h0000});
        collect(0);

        // 4096 does not fit: saturate
        send_beat(16'h4580, 1'b1);
        exp_q.push_back({1'b1, 16'd1, 16'h457F});
        collect(0);

        // Backpressure then a fresh vector with no residue
        for (int i = 0; i < 4; i++) send_beat(16'h3F00, i == 3);
        exp_q.push_back({1'b0, 16'd4, 16'h4000});
        collect(5);
        send_beat(16'h3F80, 1'b1);
        exp_q.push_back({1'b0, 16'd1, 16'h3F80});
        collect(0);

        // clear_i after three beats; the beat coinciding with clear is dropped
        for (int i = 0; i < 3; i++) send_beat(16'h3F80, 1'b0);
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h3F80;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("clr_in_ready", in_ready, 1);
        check("clr_sum_valid", sum_valid, 0);
        send_beat(16'h3F00, 1'b1);
        exp_q.push_back({1'b0, 16'd1, 16'h3F00});
        collect(0);

        // clear_i while a result is waiting
        send_beat(16'h3F80, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("pre_clr_valid", sum_valid, 1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check("clr_out_valid", sum_valid, 0);
        check("clr_out_sum", sum, 0);
        check("clr_out_count", count, 0);
        send_beat(16'h4000, 1'b1);
        exp_q.push_back({1'b0, 16'd1, 16'h4000});
        collect(0);

        // rst_i mid-vector
        for (int i = 0; i < 3; i++) send_beat(16'h3F80, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_valid", sum_valid, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_overflow", ovf, 0);
        rst = 1'b0;
        send_beat(16'h3F00, 1'b1);
        exp_q.push_back({1'b0, 16'd1, 16'h3F00});
        collect(0);

        // Random vectors against the model
        for (int v = 0; v < 60; v++) run_random_vector();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end, expected finish");
        $fatal(1);
    end

endmodule
